// File: rtl/modexp_ladder_dual.sv
// rtl/modexp_ladder_dual.sv - Montgomery-ladder x^e mod m controller driving two external multipliers
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, skip_lz        request (IDLE only), skip leading exponent zeros
//   in_x/in_m/in_r/in_r2  base, modulus, R mod m, R^2 mod m
//   in_e, lene            exponent and number of its low bits to process
//   mulN_start/a/b        multiplier request and operands (held until mulN_done)
//   mul_m                 latched modulus shared by both multipliers
//   mulN_done/res         multiplier completion pulse and result
//   busy, done, result    status, completion pulse, final x^e mod m

module modexp_ladder_dual #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024,
  parameter int LEN_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 skip_lz,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_WIDTH-1:0] lene,
  output logic                 mul0_start,
  output logic                 mul1_start,
  output logic [WIDTH-1:0]     mul0_a,
  output logic [WIDTH-1:0]     mul0_b,
  output logic [WIDTH-1:0]     mul1_a,
  output logic [WIDTH-1:0]     mul1_b,
  output logic [WIDTH-1:0]     mul_m,
  input  logic                 mul0_done,
  input  logic                 mul1_done,
  input  logic [WIDTH-1:0]     mul0_res,
  input  logic [WIDTH-1:0]     mul1_res,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_INIT, S_SCAN, S_STEP,
    S_WAIT_STEP, S_FINAL, S_WAIT_FINAL, S_DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_q;       // ladder accumulator A (Montgomery domain)
  logic [WIDTH-1:0]     x_q;       // ladder register X = A * x
  logic [WIDTH-1:0]     r0_q;      // mul0 result captured in its own done cycle
  logic [WIDTH-1:0]     r1_q;      // mul1 result captured in its own done cycle
  logic [EXP_WIDTH-1:0] e_q;
  logic [IDX_W-1:0]     i_q;
  logic                 skip_q;
  logic                 seen_q;    // a bit has already gone through STEP
  logic                 len_zero_q;
  logic                 f0_q;
  logic                 f1_q;

  logic [LEN_WIDTH-1:0] lene_sat;
  logic                 bit_i;
  logic                 got0;
  logic                 got1;
  logic [WIDTH-1:0]     v0;
  logic [WIDTH-1:0]     v1;

  assign lene_sat = (lene > LEN_WIDTH'(EXP_WIDTH)) ? LEN_WIDTH'(EXP_WIDTH) : lene;
  assign bit_i    = e_q[i_q];
  // A done arriving this cycle counts immediately, its value bypasses the capture register.
  assign got0     = f0_q | mul0_done;
  assign got1     = f1_q | mul1_done;
  assign v0       = mul0_done ? mul0_res : r0_q;
  assign v1       = mul1_done ? mul1_res : r1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mul0_start <= 1'b0;
      mul1_start <= 1'b0;
      result     <= '0;
      f0_q       <= 1'b0;
      f1_q       <= 1'b0;
    end else begin
      mul0_start <= 1'b0;
      mul1_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Operands for the to-Montgomery conversion are loaded now so they are stable at the pulse.
            mul0_a     <= in_x;
            mul0_b     <= in_r2;
            mul_m      <= in_m;
            e_q        <= in_e;
            skip_q     <= skip_lz;
            a_q        <= in_r;
            i_q        <= IDX_W'(lene_sat - 1'b1);
            len_zero_q <= (lene_sat == '0);
            seen_q     <= 1'b0;
            busy       <= 1'b1;
            state      <= S_INIT;
          end
        end
        S_INIT: begin
          mul0_start <= 1'b1;
          state      <= S_WAIT_INIT;
        end
        S_WAIT_INIT: begin
          if (mul0_done) begin
            x_q   <= mul0_res;
            state <= len_zero_q ? S_FINAL : S_SCAN;
          end
        end
        S_SCAN: begin
          if (skip_q && !seen_q && !bit_i) begin
            if (i_q == '0) state <= S_FINAL;
            else           i_q   <= i_q - 1'b1;
          end else begin
            state <= S_STEP;
          end
        end
        S_STEP: begin
          mul0_start <= 1'b1;
          mul1_start <= 1'b1;
          mul0_a     <= a_q;
          mul0_b     <= x_q;
          mul1_a     <= bit_i ? x_q : a_q;
          mul1_b     <= bit_i ? x_q : a_q;
          seen_q     <= 1'b1;
          f0_q       <= 1'b0;
          f1_q       <= 1'b0;
          state      <= S_WAIT_STEP;
        end
        S_WAIT_STEP: begin
          if (mul0_done) begin
            f0_q <= 1'b1;
            r0_q <= mul0_res;
          end
          if (mul1_done) begin
            f1_q <= 1'b1;
            r1_q <= mul1_res;
          end
          if (got0 && got1) begin
            f0_q <= 1'b0;
            f1_q <= 1'b0;
            if (bit_i) begin
              a_q <= v0;
              x_q <= v1;
            end else begin
              x_q <= v0;
              a_q <= v1;
            end
            if (i_q == '0) begin
              state <= S_FINAL;
            end else begin
              i_q   <= i_q - 1'b1;
              state <= S_SCAN;
            end
          end
        end
        S_FINAL: begin
          // MontMul(A, 1) leaves the Montgomery domain.
          mul0_a     <= a_q;
          mul0_b     <= WIDTH'(1);
          mul0_start <= 1'b1;
          state      <= S_WAIT_FINAL;
        end
        S_WAIT_FINAL: begin
          if (mul0_done) begin
            result <= mul0_res;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ladder_dual.sv
// tb/tb_modexp_ladder_dual.sv - directed bench for modexp_ladder_dual with behavioural Montgomery multipliers

module tb_modexp_ladder_dual;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        skip_lz = 1'b0;
  logic [15:0] in_x = '0, in_m = 16'd241, in_r = 16'd225, in_r2 = 16'd15;
  logic [15:0] in_e = '0;
  logic [4:0]  lene = '0;
  logic        mul0_start, mul1_start;
  logic [15:0] mul0_a, mul0_b, mul1_a, mul1_b, mul_m;
  logic        mul0_done = 1'b0, mul1_done = 1'b0;
  logic [15:0] mul0_res = '0, mul1_res = '0;
  logic        busy, done;
  logic [15:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;

  int cnt0 = 0, cnt1 = 0, dcnt = 0;
  int hold_err = 0, ovl_err = 0;
  int lat0 = 5, lat1 = 5;

  logic        pend0 = 1'b0, pend1 = 1'b0;
  logic [15:0] a0, b0, a1, b1, m0, m1;
  int          cd0 = 0, cd1 = 0;

  modexp_ladder_dual #(.WIDTH(16), .EXP_WIDTH(16), .LEN_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .skip_lz(skip_lz),
    .in_x(in_x), .in_m(in_m), .in_r(in_r), .in_r2(in_r2), .in_e(in_e), .lene(lene),
    .mul0_start(mul0_start), .mul1_start(mul1_start),
    .mul0_a(mul0_a), .mul0_b(mul0_b), .mul1_a(mul1_a), .mul1_b(mul1_b), .mul_m(mul_m),
    .mul0_done(mul0_done), .mul1_done(mul1_done), .mul0_res(mul0_res), .mul1_res(mul1_res),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // a*b*2^-16 mod m for odd m.
  function automatic logic [15:0] mont(input logic [15:0] a, input logic [15:0] b, input logic [15:0] m);
    logic [63:0] t;
    t = 64'(a) * 64'(b);
    for (int k = 0; k < 16; k++) begin
      if (t[0]) t = t + 64'(m);
      t = t >> 1;
    end
    if (t >= 64'(m)) t = t - 64'(m);
    return t[15:0];
  endfunction

  always @(posedge clk) begin
    if (mul0_start) cnt0 <= cnt0 + 1;
    if (mul1_start) cnt1 <= cnt1 + 1;
    if (done) dcnt <= dcnt + 1;
    if ((mul0_start || mul1_start) && (pend0 || pend1)) ovl_err <= ovl_err + 1;
    if ((pend0 && (mul0_a !== a0 || mul0_b !== b0)) || (pend1 && (mul1_a !== a1 || mul1_b !== b1)))
      hold_err <= hold_err + 1;
  end

  always @(posedge clk) begin
    mul0_done <= 1'b0;
    if (pend0) begin
      if (cd0 <= 1) begin
        mul0_done <= 1'b1;
        mul0_res  <= mont(a0, b0, m0);
        pend0     <= 1'b0;
      end else cd0 <= cd0 - 1;
    end
    if (mul0_start) begin
      pend0 <= 1'b1; a0 <= mul0_a; b0 <= mul0_b; m0 <= mul_m; cd0 <= lat0;
    end
  end

  always @(posedge clk) begin
    mul1_done <= 1'b0;
    if (pend1) begin
      if (cd1 <= 1) begin
        mul1_done <= 1'b1;
        mul1_res  <= mont(a1, b1, m1);
        pend1     <= 1'b0;
      end else cd1 <= cd1 - 1;
    end
    if (mul1_start) begin
      pend1 <= 1'b1; a1 <= mul1_a; b1 <= mul1_b; m1 <= mul_m; cd1 <= lat1;
    end
  end

  task automatic run_op(input logic [15:0] x, input logic [15:0] e, input logic [4:0] ln,
                        input logic sk, input int restart_at,
                        output logic [15:0] res, output int n0, output int n1, output int nd,
                        output logic busy_after);
    int s0, s1, sd;
    s0 = cnt0; s1 = cnt1; sd = dcnt;
    res = 'x;
    busy_after = 1'bx;
    @(negedge clk);
    in_x = x; in_e = e; lene = ln; skip_lz = sk; start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (c == restart_at) in_x = 16'd5;
      if (done === 1'b1) begin
        res = result;
        break;
      end
    end
    start = 1'b0;
    if (res === 'x) $display("FAIL run_timeout: no done within 3000 cycles (x=%0d e=%0d)", x, e);
    @(negedge clk);
    busy_after = busy;
    repeat (3) @(negedge clk);
    n0 = cnt0 - s0; n1 = cnt1 - s1; nd = dcnt - sd;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total_cnt += 4;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    if ({mul0_start, mul1_start} !== 2'b00) $display("FAIL reset_starts: got %b expected 00", {mul0_start, mul1_start}); else pass_cnt++;
    if (result !== 16'd0) $display("FAIL reset_result: got %0d expected 0", result); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] r; int n0, n1, nd; logic ba;
    run_op(16'd3, 16'd5, 5'd3, 1'b1, -1, r, n0, n1, nd, ba);
    total_cnt += 6;
    if (r !== 16'd2) $display("FAIL basic_result: got %0d expected 2", r); else pass_cnt++;
    if (n1 !== 3) $display("FAIL basic_mul1_starts: got %0d expected 3", n1); else pass_cnt++;
    if (n0 !== 5) $display("FAIL basic_mul0_starts: got %0d expected 5", n0); else pass_cnt++;
    if (nd !== 1) $display("FAIL basic_done_pulses: got %0d expected 1", nd); else pass_cnt++;
    if (ba !== 1'b0) $display("FAIL basic_busy_after_done: got %b expected 0", ba); else pass_cnt++;
    if (hold_err !== 0) $display("FAIL basic_operand_hold: got %0d violations expected 0", hold_err); else pass_cnt++;
  endtask

  task automatic test_skip_lz;
    logic [15:0] r; int n0, n1, nd; logic ba;
    run_op(16'd7, 16'h0005, 5'd8, 1'b0, -1, r, n0, n1, nd, ba);
    total_cnt += 2;
    if (r !== 16'd178) $display("FAIL noskip_result: got %0d expected 178", r); else pass_cnt++;
    if (n1 !== 8) $display("FAIL noskip_mul1_starts: got %0d expected 8", n1); else pass_cnt++;
    run_op(16'd7, 16'h0005, 5'd8, 1'b1, -1, r, n0, n1, nd, ba);
    total_cnt += 2;
    if (r !== 16'd178) $display("FAIL skip_result: got %0d expected 178", r); else pass_cnt++;
    if (n1 !== 3) $display("FAIL skip_mul1_starts: got %0d expected 3", n1); else pass_cnt++;
  endtask

  task automatic test_zero_exp;
    logic [15:0] r; int n0, n1, nd; logic ba;
    run_op(16'd9, 16'h0000, 5'd4, 1'b1, -1, r, n0, n1, nd, ba);
    total_cnt += 2;
    if (r !== 16'd1) $display("FAIL zero_skip_result: got %0d expected 1", r); else pass_cnt++;
    if (n1 !== 0) $display("FAIL zero_skip_mul1_starts: got %0d expected 0", n1); else pass_cnt++;
    run_op(16'd9, 16'h0000, 5'd4, 1'b0, -1, r, n0, n1, nd, ba);
    total_cnt += 2;
    if (r !== 16'd1) $display("FAIL zero_noskip_result: got %0d expected 1", r); else pass_cnt++;
    if (n1 !== 4) $display("FAIL zero_noskip_mul1_starts: got %0d expected 4", n1); else pass_cnt++;
    run_op(16'd9, 16'h0007, 5'd0, 1'b0, -1, r, n0, n1, nd, ba);
    total_cnt += 2;
    if (r !== 16'd1) $display("FAIL lene0_result: got %0d expected 1", r); else pass_cnt++;
    if (n0 !== 2) $display("FAIL lene0_mul0_starts: got %0d expected 2", n0); else pass_cnt++;
  endtask

  task automatic test_done_skew;
    logic [15:0] r; int n0, n1, nd; logic ba;
    lat0 = 9; lat1 = 2;
    run_op(16'd3, 16'd5, 5'd3, 1'b1, -1, r, n0, n1, nd, ba);
    total_cnt += 1;
    if (r !== 16'd2) $display("FAIL skew_slow0_result: got %0d expected 2", r); else pass_cnt++;
    lat0 = 2; lat1 = 9;
    run_op(16'd3, 16'd5, 5'd3, 1'b1, -1, r, n0, n1, nd, ba);
    total_cnt += 3;
    if (r !== 16'd2) $display("FAIL skew_slow1_result: got %0d expected 2", r); else pass_cnt++;
    if (ovl_err !== 0) $display("FAIL skew_early_advance: got %0d starts while busy expected 0", ovl_err); else pass_cnt++;
    if (hold_err !== 0) $display("FAIL skew_operand_hold: got %0d violations expected 0", hold_err); else pass_cnt++;
    lat0 = 5; lat1 = 5;
  endtask

  task automatic test_reset_mid_op;
    logic [15:0] r; int n0, n1, nd; logic ba; int s1, sq;
    logic seen_step2;
    s1 = cnt1;
    seen_step2 = 1'b0;
    @(negedge clk);
    in_x = 16'd3; in_e = 16'd5; lene = 5'd3; skip_lz = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (cnt1 - s1 >= 2) begin seen_step2 = 1'b1; break; end
      @(negedge clk);
    end
    total_cnt += 1;
    if (seen_step2 !== 1'b1) $display("FAIL midreset_reach_step2: got %b expected 1", seen_step2); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt += 3;
    if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else pass_cnt++;
    if ({mul0_start, mul1_start} !== 2'b00) $display("FAIL midreset_starts: got %b expected 00", {mul0_start, mul1_start}); else pass_cnt++;
    if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done); else pass_cnt++;
    sq = cnt0 + cnt1 + dcnt;
    repeat (20) @(negedge clk);
    total_cnt += 1;
    if (cnt0 + cnt1 + dcnt !== sq) $display("FAIL midreset_quiet: got %0d pulses expected 0", cnt0 + cnt1 + dcnt - sq); else pass_cnt++;
    run_op(16'd3, 16'd5, 5'd3, 1'b1, -1, r, n0, n1, nd, ba);
    total_cnt += 1;
    if (r !== 16'd2) $display("FAIL midreset_rerun_result: got %0d expected 2", r); else pass_cnt++;
  endtask

  task automatic test_busy_restart_sat;
    logic [15:0] r; int n0, n1, nd; logic ba;
    run_op(16'd7, 16'h0005, 5'd31, 1'b0, 10, r, n0, n1, nd, ba);
    total_cnt += 4;
    if (r !== 16'd178) $display("FAIL sat_result: got %0d expected 178", r); else pass_cnt++;
    if (n1 !== 16) $display("FAIL sat_mul1_starts: got %0d expected 16", n1); else pass_cnt++;
    if (n0 !== 18) $display("FAIL sat_mul0_starts: got %0d expected 18", n0); else pass_cnt++;
    if (nd !== 1) $display("FAIL restart_done_pulses: got %0d expected 1", nd); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_skip_lz;
    test_zero_exp;
    test_done_skew;
    test_reset_mid_op;
    test_busy_restart_sat;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
